// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared types for the multi-word add/subtract sequencer
package au_pkg;

    typedef enum logic {
        AU_SEQ_IDLE = 1'b0,
        AU_SEQ_BUSY = 1'b1
    } au_seq_state_e;

endpackage

// File: rtl/au_add_mword_seq_if.sv
// rtl/au_add_mword_seq_if.sv - word-stream handshake bundle between producer, sequencer and consumer
interface au_add_mword_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_co;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_s, out_idx, out_last, out_co, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_s, out_idx, out_last, out_co, out_ovf
    );
endinterface

// File: rtl/AU_add_cfast.sv
// rtl/AU_add_cfast.sv - parallel-prefix adder with carry-in/out
// ARCH 0 = Kogge-Stone, 1 = Sklansky, 2 = serial prefix (ripple).
module AU_add_cfast #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    // Position 0 carries ci as a generate, so group[i] is the carry into bit i.
    logic [WIDTH:0] gen;
    logic [WIDTH:0] prop;
    logic [WIDTH:0] grp;

    assign gen  = {a & b, ci};
    assign prop = {a ^ b, 1'b0};

    always_comb begin
        logic [WIDTH:0] gg;
        logic [WIDTH:0] pp;
        logic [WIDTH:0] ng;
        logic [WIDTH:0] np;
        int             j;
        gg = gen;
        pp = prop;
        ng = gen;
        np = prop;
        j  = 0;
        if (ARCH == 2) begin
            for (int i = 1; i <= WIDTH; i++) begin
                gg[i] = gen[i] | (prop[i] & gg[i-1]);
            end
        end else begin
            for (int l = 0; (1 << l) <= WIDTH; l++) begin
                ng = gg;
                np = pp;
                for (int i = 0; i <= WIDTH; i++) begin
                    if (ARCH == 0) begin
                        if (i >= (1 << l)) begin
                            ng[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                            np[i] = pp[i] & pp[i-(1<<l)];
                        end
                    end else if (((i >> l) & 1) == 1) begin
                        j     = ((i >> l) << l) - 1;
                        ng[i] = gg[i] | (pp[i] & gg[j]);
                        np[i] = pp[i] & pp[j];
                    end
                end
                gg = ng;
                pp = np;
            end
        end
        grp = gg;
    end

    assign s  = prop[WIDTH:1] ^ grp[WIDTH-1:0];
    assign co = grp[WIDTH];
endmodule

// File: rtl/au_add_mword_seq.sv
// rtl/au_add_mword_seq.sv - LSW-first multi-word add/subtract through one narrow adder
// The carry is chained between beats in carry_q; the first beat takes its carry-in from in_sub.
module au_add_mword_seq
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0,
    parameter int IDXW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    au_add_mword_seq_if.slave   bus
);
    au_seq_state_e    state_q, state_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_co_q, out_co_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_ready;
    logic             accept;
    logic             first;
    logic             sub_eff;
    logic [WIDTH-1:0] eff_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic [IDXW-1:0]  index;

    assign in_ready = !flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign first    = (state_q == AU_SEQ_IDLE);
    assign sub_eff  = first ? bus.in_sub : sub_q;
    assign eff_b    = sub_eff ? ~bus.in_b : bus.in_b;
    assign add_ci   = first ? bus.in_sub : carry_q;
    assign index    = first ? '0 : idx_q;

    AU_add_cfast #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_add (
        .a  (bus.in_a),
        .b  (eff_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_co_d    = out_co_q;
        out_ovf_d   = out_ovf_q;
        if (flush) begin
            state_d     = AU_SEQ_IDLE;
            sub_d       = 1'b0;
            carry_d     = 1'b0;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            state_d     = bus.in_last ? AU_SEQ_IDLE : AU_SEQ_BUSY;
            sub_d       = sub_eff;
            carry_d     = add_co;
            idx_d       = index + IDXW'(1);
            out_valid_d = 1'b1;
            out_s_d     = add_s;
            out_idx_d   = index;
            out_last_d  = bus.in_last;
            out_co_d    = add_co;
            out_ovf_d   = (bus.in_a[WIDTH-1] == eff_b[WIDTH-1]) &&
                          (add_s[WIDTH-1] != bus.in_a[WIDTH-1]);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= AU_SEQ_IDLE;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_co_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_co_q    <= out_co_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_co    = out_co_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
